cp0_unit: RTL and testbench

Coprocessor 0 for the P7 pipeline: the consumer side of the per-stage exception reporting chain. It collects the merged exception flag and code carried down to the M stage, together with the external hardware interrupt lines, and decides whether the pipeline must trap. It records Status, Cause and EPC, serves `mfc0`/`mtc0` accesses, and clears the exception level on `eret`.

---
 rtl/cp0_unit_if.sv | 25 ++
 rtl/cp0_unit.sv | 97 +++++++++
 tb/tb_cp0_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/cp0_unit_if.sv
// Pipeline-to-CP0 bus: M-stage exception/mtc0/eret inputs and the trap/read results.
interface cp0_unit_if;
    logic        exc_get;
    logic [4:0]  exc_code;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [5:0]  hw_int;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        eret;
    logic [31:0] rdata;
    logic [31:0] epc;
    logic        req;

    modport master (
        output exc_get, exc_code, pc_m, bd_m, hw_int, we, addr, wdata, eret,
        input  rdata, epc, req
    );

    modport slave (
        input  exc_get, exc_code, pc_m, bd_m, hw_int, we, addr, wdata, eret,
        output rdata, epc, req
    );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0: trap decision for M-stage exceptions and interrupts,
// Status/Cause/EPC state, mfc0/mtc0 access and eret handling.
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h0000_7000
) (
    input logic        clk,
    input logic        reset,
    cp0_unit_if.slave  bus
);
    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  srIm,      srImNext;
    logic        srExl,     srExlNext;
    logic        srIe,      srIeNext;
    logic        causeBd,   causeBdNext;
    logic [5:0]  causeIp;
    logic [4:0]  causeExc,  causeExcNext;
    logic [31:0] epcReg,    epcRegNext;

    logic        intReq;
    logic        excReq;
    logic [31:0] trapPc;

    // Trap decision; interrupts take priority over a carried exception.
    always_comb begin
        intReq  = (|(bus.hw_int & srIm)) & srIe & ~srExl;
        excReq  = bus.exc_get & ~srExl;
        bus.req = intReq | excReq;
        trapPc  = bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m;
    end

    // Next-state: a trap squashes any mtc0/eret in the same cycle.
    always_comb begin
        srImNext     = srIm;
        srExlNext    = srExl;
        srIeNext     = srIe;
        causeBdNext  = causeBd;
        causeExcNext = causeExc;
        epcRegNext   = epcReg;
        if (bus.req) begin
            srExlNext    = 1'b1;
            causeExcNext = intReq ? 5'd0 : bus.exc_code;
            causeBdNext  = bus.bd_m;
            epcRegNext   = {trapPc[31:2], 2'b00};
        end else begin
            if (bus.we) begin
                case (bus.addr)
                    ADDR_SR: begin
                        srImNext  = bus.wdata[15:10];
                        srExlNext = bus.wdata[1];
                        srIeNext  = bus.wdata[0];
                    end
                    ADDR_EPC: epcRegNext = {bus.wdata[31:2], 2'b00};
                    default: ;
                endcase
            end
            // Applied after the write so a stray we+eret still leaves EXL clear.
            if (bus.eret) srExlNext = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            srIm     <= 6'd0;
            srExl    <= 1'b0;
            srIe     <= 1'b0;
            causeBd  <= 1'b0;
            causeIp  <= 6'd0;
            causeExc <= 5'd0;
            epcReg   <= 32'd0;
        end else begin
            srIm     <= srImNext;
            srExl    <= srExlNext;
            srIe     <= srIeNext;
            causeBd  <= causeBdNext;
            causeIp  <= bus.hw_int;
            causeExc <= causeExcNext;
            epcReg   <= epcRegNext;
        end
    end

    // Read port shows pre-edge contents; no bypass from a same-cycle mtc0.
    always_comb begin
        bus.rdata = 32'd0;
        case (bus.addr)
            ADDR_SR:    bus.rdata = {16'd0, srIm, 8'd0, srExl, srIe};
            ADDR_CAUSE: bus.rdata = {causeBd, 15'd0, causeIp, 3'd0, causeExc, 2'b00};
            ADDR_EPC:   bus.rdata = epcReg;
            ADDR_PRID:  bus.rdata = PRID;
            default:    bus.rdata = 32'd0;
        endcase
        bus.epc = epcReg;
    end
endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares req/rdata/epc.
module tb_cp0_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;

    cp0_unit_if bus();

    cp0_unit #(.PRID(32'h0000_7000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        req;
        logic [31:0] rdata;
        logic [31:0] epc;
    } exp_t;

    exp_t expQ[$];
    int   applied = 0;
    int   miscompares = 0;

    // Drive one cycle of inputs just after the edge and queue what must be seen.
    task automatic vec(input string nm, input logic rst, input logic eg, input logic [4:0] ec,
                       input logic [31:0] pc, input logic bd, input logic [5:0] hw,
                       input logic w, input logic [4:0] a, input logic [31:0] wd, input logic er,
                       input logic xReq, input logic [31:0] xRd, input logic [31:0] xEpc);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rst;
        bus.exc_get  = eg;
        bus.exc_code = ec;
        bus.pc_m     = pc;
        bus.bd_m     = bd;
        bus.hw_int   = hw;
        bus.we       = w;
        bus.addr     = a;
        bus.wdata    = wd;
        bus.eret     = er;
        e.name  = nm;
        e.req   = xReq;
        e.rdata = xRd;
        e.epc   = xEpc;
        expQ.push_back(e);
    endtask

    // Monitor: the outputs are combinational, so each queued cycle is sampled mid-period.
    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            exp_t e;
            e = expQ.pop_front();
            applied++;
            if (bus.req !== e.req || bus.rdata !== e.rdata || bus.epc !== e.epc) begin
                miscompares++;
                $display("FAIL %s: got req=%0b rdata=%h epc=%h, want req=%0b rdata=%h epc=%h",
                         e.name, bus.req, bus.rdata, bus.epc, e.req, e.rdata, e.epc);
            end
        end
    end

    initial begin
        bus.exc_get = 1'b0; bus.exc_code = 5'd0; bus.pc_m = 32'd0; bus.bd_m = 1'b0;
        bus.hw_int = 6'd0; bus.we = 1'b0; bus.addr = 5'd0; bus.wdata = 32'd0; bus.eret = 1'b0;

        //   name              rst eg  code   pc_m          bd  hw_int     we  addr    wdata          er   req  rdata          epc
        vec("rst_sr",          1, 0, 5'd0,  32'h0,        0, 6'b000000, 0, 5'd12, 32'h0,         0,   0, 32'h0,         32'h0);
        vec("rst_cause",       1, 0, 5'd0,  32'h0,        0, 6'b000000, 0, 5'd13, 32'h0,         0,   0, 32'h0,         32'h0);
        vec("rst_epc",         1, 0, 5'd0,  32'h0,        0, 6'b000000, 0, 5'd14, 32'h0,         0,   0, 32'h0,         32'h0);
        vec("rst_prid",        1, 0, 5'd0,  32'h0,        0, 6'b000000, 0, 5'd15, 32'h0,         0,   0, 32'h0000_7000, 32'h0);
        vec("mtc0_sr",         0, 0, 5'd0,  32'h0,        0, 6'b000000, 1, 5'd12, 32'h0000_fc01, 0,   0, 32'h0,         32'h0);
        vec("int_req",         0, 0, 5'd0,  32'h0000_1000,0, 6'b000100, 0, 5'd12, 32'h0,         0,   1, 32'h0000_fc01, 32'h0);
        vec("cause_int",       0, 0, 5'd0,  32'h0,        0, 6'b000100, 0, 5'd13, 32'h0,         0,   0, 32'h0000_1000, 32'h0000_1000);
        vec("sr_exl_set",      0, 0, 5'd0,  32'h0,        0, 6'b000000, 0, 5'd12, 32'h0,         0,   0, 32'h0000_fc03, 32'h0000_1000);
        vec("eret_clear",      0, 0, 5'd0,  32'h0,        0, 6'b000000, 0, 5'd13, 32'h0,         1,   0, 32'h0,         32'h0000_1000);
        vec("adel_bd_trap",    0, 1, 5'd4,  32'h0000_3006,1, 6'b000000, 0, 5'd12, 32'h0,         0,   1, 32'h0000_fc01, 32'h0000_1000);
        vec("cause_adel",      0, 0, 5'd0,  32'h0,        0, 6'b000000, 0, 5'd13, 32'h0,         0,   0, 32'h8000_0010, 32'h0000_3000);
        vec("exc_dropped_exl", 0, 1, 5'd12, 32'h0000_5000,0, 6'b000000, 0, 5'd14, 32'h0,         0,   0, 32'h0000_3000, 32'h0000_3000);
        vec("cause_unchanged", 0, 0, 5'd0,  32'h0,        0, 6'b000000, 0, 5'd13, 32'h0,         0,   0, 32'h8000_0010, 32'h0000_3000);
        vec("eret_pending_int",0, 0, 5'd0,  32'h0,        0, 6'b000001, 0, 5'd12, 32'h0,         1,   0, 32'h0000_fc03, 32'h0000_3000);
        vec("int_beats_ov",    0, 1, 5'd12, 32'h0000_4008,0, 6'b000001, 0, 5'd13, 32'h0,         0,   1, 32'h8000_0410, 32'h0000_3000);
        vec("cause_int_prio",  0, 0, 5'd0,  32'h0,        0, 6'b000000, 0, 5'd13, 32'h0,         0,   0, 32'h0000_0400, 32'h0000_4008);
        vec("mtc0_epc",        0, 0, 5'd0,  32'h0,        0, 6'b000000, 1, 5'd14, 32'h1234_5677, 0,   0, 32'h0000_4008, 32'h0000_4008);
        vec("epc_aligned",     0, 0, 5'd0,  32'h0,        0, 6'b000000, 0, 5'd14, 32'h0,         0,   0, 32'h1234_5674, 32'h1234_5674);
        vec("we_and_eret",     0, 0, 5'd0,  32'h0,        0, 6'b000000, 1, 5'd12, 32'h0000_fc03, 1,   0, 32'h0000_fc03, 32'h1234_5674);
        vec("sr_after_both",   0, 0, 5'd0,  32'h0,        0, 6'b000000, 0, 5'd12, 32'h0,         0,   0, 32'h0000_fc01, 32'h1234_5674);
        vec("trap_squash_we",  0, 0, 5'd0,  32'h0000_2004,1, 6'b000010, 1, 5'd12, 32'h0,         0,   1, 32'h0000_fc01, 32'h1234_5674);
        vec("sr_write_lost",   0, 0, 5'd0,  32'h0,        0, 6'b000000, 0, 5'd12, 32'h0,         0,   0, 32'h0000_fc03, 32'h0000_2000);
        vec("unimpl_addr",     0, 0, 5'd0,  32'h0,        0, 6'b000000, 0, 5'd7,  32'h0,         0,   0, 32'h0,         32'h0000_2000);
        vec("mtc0_cause",      0, 0, 5'd0,  32'h0,        0, 6'b000000, 1, 5'd13, 32'hffff_ffff, 0,   0, 32'h8000_0000, 32'h0000_2000);
        vec("cause_ro",        0, 0, 5'd0,  32'h0,        0, 6'b000000, 0, 5'd13, 32'h0,         0,   0, 32'h8000_0000, 32'h0000_2000);
        vec("async_rst_sr",    1, 0, 5'd0,  32'h0,        0, 6'b000000, 0, 5'd12, 32'h0,         0,   0, 32'h0,         32'h0);
        vec("async_rst_epc",   1, 0, 5'd0,  32'h0,        0, 6'b000000, 0, 5'd14, 32'h0,         0,   0, 32'h0,         32'h0);
        vec("ri_bd_wrap",      0, 1, 5'd10, 32'h0000_0002,1, 6'b000000, 0, 5'd13, 32'h0,         0,   1, 32'h0,         32'h0);
        vec("epc_wrapped",     0, 0, 5'd0,  32'h0,        0, 6'b000000, 0, 5'd14, 32'h0,         0,   0, 32'hffff_fffc, 32'hffff_fffc);
        vec("cause_ri",        0, 0, 5'd0,  32'h0,        0, 6'b000000, 0, 5'd13, 32'h0,         0,   0, 32'h8000_0028, 32'hffff_fffc);

        repeat (2) @(posedge clk);
        if (expQ.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
